// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl
//   Brute-force key-search scheduler for the RC4 decode core. Walks the secret
//   key from KEY_START to KEY_MAX. For each key it pulses core_start_o and then
//   waits for the core's done/valid verdict, giving up on a key after TIMEOUT_CYC
//   cycles. The search stops on the first valid plaintext, on key exhaustion or
//   on stop_i.
//
//   State | Meaning
//   ------+------------------------------------------------------------
//   IDLE      | no search running (after reset or after an abort)
//   LAUNCH    | core_start_o is high for this single cycle with core_key_o
//   WAIT      | waiting for core_done_i or for the wait counter to expire
//   FOUND     | a valid key was found; found_key_o holds it
//   EXHAUSTED | KEY_MAX was tried without success
//
// Ports
//   clk_i          system clock
//   reset_i        synchronous reset, active high
//   start_i        begin or restart a search (ignored while busy)
//   stop_i         abort the running search; blocks start when idle
//   core_start_o   one-cycle start pulse to the decode core
//   core_key_o     key presented to the core
//   core_done_i    one-cycle pulse from the core: decryption finished
//   core_valid_i   qualifies core_done_i: plaintext looked valid
//   busy_o         high in LAUNCH or WAIT
//   found_o        sticky: valid key found
//   exhausted_o    sticky: KEY_MAX tried without success
//   timeout_o      sticky: at least one attempt timed out
//   found_key_o    key that produced valid plaintext
//   attempts_o     completed attempts (done or timeout), saturating
module rc4_key_search_ctrl #(
    parameter int               KEY_W       = 24,
    parameter logic [KEY_W-1:0] KEY_START   = '0,
    parameter logic [KEY_W-1:0] KEY_MAX     = 24'h3FFFFF,
    parameter int               TIMEOUT_CYC = 65536
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             core_start_o,
    output logic [KEY_W-1:0] core_key_o,
    input  logic             core_done_i,
    input  logic             core_valid_i,
    output logic             busy_o,
    output logic             found_o,
    output logic             exhausted_o,
    output logic             timeout_o,
    output logic [KEY_W-1:0] found_key_o,
    output logic [KEY_W-1:0] attempts_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FOUND,
        S_EXHAUSTED
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             core_start_q, core_start_d;
    logic [KEY_W-1:0] core_key_q, core_key_d;
    logic             busy_q, busy_d;
    logic             found_q, found_d;
    logic             exhausted_q, exhausted_d;
    logic             timeout_q, timeout_d;
    logic [KEY_W-1:0] found_key_q, found_key_d;
    logic [KEY_W-1:0] attempts_q, attempts_d;
    logic [KEY_W-1:0] attempts_inc;

    assign attempts_inc = (attempts_q == '1) ? attempts_q : attempts_q + KEY_W'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            core_start_q <= 1'b0;
            core_key_q   <= KEY_START;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            timeout_q    <= 1'b0;
            found_key_q  <= '0;
            attempts_q   <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            core_start_q <= core_start_d;
            core_key_q   <= core_key_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
            timeout_q    <= timeout_d;
            found_key_q  <= found_key_d;
            attempts_q   <= attempts_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        core_key_d  = core_key_q;
        found_d     = found_q;
        exhausted_d = exhausted_q;
        timeout_d   = timeout_q;
        found_key_d = found_key_q;
        attempts_d  = attempts_q;

        case (state_q)
            S_IDLE, S_FOUND, S_EXHAUSTED: begin
                if (start_i && !stop_i) begin
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    timeout_d   = 1'b0;
                    attempts_d  = '0;
                    core_key_d  = KEY_START;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = stop_i ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                // stop wins over a verdict or a timeout arriving in the same cycle
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (core_done_i || (wait_cnt_q == CNT_LAST)) begin
                    attempts_d = attempts_inc;
                    if (!core_done_i) begin
                        timeout_d = 1'b1;
                    end
                    if (core_done_i && core_valid_i) begin
                        found_key_d = core_key_q;
                        found_d     = 1'b1;
                        state_d     = S_FOUND;
                    end else if (core_key_q == KEY_MAX) begin
                        exhausted_d = 1'b1;
                        state_d     = S_EXHAUSTED;
                    end else begin
                        core_key_d = core_key_q + KEY_W'(1);
                        state_d    = S_LAUNCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        core_start_d = (state_d == S_LAUNCH);
        busy_d       = (state_d == S_LAUNCH) || (state_d == S_WAIT);
    end

    assign core_start_o = core_start_q;
    assign core_key_o   = core_key_q;
    assign busy_o       = busy_q;
    assign found_o      = found_q;
    assign exhausted_o  = exhausted_q;
    assign timeout_o    = timeout_q;
    assign found_key_o  = found_key_q;
    assign attempts_o   = attempts_q;

endmodule
